mem_bus_arbiter: RTL

//  Two-master arbiter directly upstream of the memory top: muxes CPU and DMA requests onto
//  the single bus_* port (addr/wdata/size/write) and routes bus_rdata/bus_pause back.

---
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_arbiter: CPU/DMA arbiter for the memory bus, DMA-priority, locks owner
// across the 2-cycle write. Optional CPU starvation guard: ARB_CPU_STARVE_GUARD_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int DMA_BURST_MAX = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_write,
  output logic        cpu_pause,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_size,
  input  logic        dma_write,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_size,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_pause
);

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  owner_e owner_q, owner_d, sel;
  logic   hold;
  logic   guard_cpu;
  logic   sel_req, sel_write;
  logic   cpu_rv_q, cpu_rv_d;
  logic   dma_rv_q, dma_rv_d;

  if (CNT_W < $clog2(DMA_BURST_MAX + 1)) begin : g_cnt_w_check
    $error("mem_bus_arbiter: CNT_W too narrow for DMA_BURST_MAX");
  end

  // Reset cancels an in-flight write: the memory drops its latch at the same time.
  assign hold = bus_pause & ~reset;

`ifdef ARB_CPU_STARVE_GUARD_EN
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!dma_req || (sel == OWN_CPU && cpu_req && !hold)) begin
      run_cnt_d = '0;
    end else if (sel == OWN_DMA && !hold && run_cnt_q != CNT_W'(DMA_BURST_MAX)) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) run_cnt_q <= '0;
    else       run_cnt_q <= run_cnt_d;
  end

  assign guard_cpu = (run_cnt_q == CNT_W'(DMA_BURST_MAX)) & cpu_req;
`else
  assign guard_cpu = 1'b0;
`endif

  always_comb begin
    sel = OWN_CPU;
    if (reset)          sel = OWN_CPU;
    else if (hold)      sel = owner_q;
    else if (guard_cpu) sel = OWN_CPU;
    else if (dma_req)   sel = OWN_DMA;
  end

  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_size  = cpu_size;
    sel_req   = cpu_req;
    sel_write = cpu_write;
    if (sel == OWN_DMA) begin
      bus_addr  = dma_addr;
      bus_wdata = dma_wdata;
      bus_size  = dma_size;
      sel_req   = dma_req;
      sel_write = dma_write;
    end
  end

  // Write strobe only in the address cycle so the memory never re-latches.
  assign bus_write = sel_write & sel_req & ~hold & ~reset;
  assign cpu_pause = (sel == OWN_DMA) | hold;
  assign dma_gnt   = ((sel == OWN_DMA) & dma_req & ~hold & ~dma_write)
                   | (hold & (owner_q == OWN_DMA));

  always_comb begin
    owner_d  = sel;
    cpu_rv_d = (sel == OWN_CPU) & cpu_req & ~cpu_write & ~hold;
    dma_rv_d = (sel == OWN_DMA) & dma_req & ~dma_write & ~hold;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_CPU;
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      cpu_rv_q <= cpu_rv_d;
      dma_rv_q <= dma_rv_d;
    end
  end

  assign cpu_rvalid = cpu_rv_q;
  assign dma_rvalid = dma_rv_q;
  assign rdata      = bus_rdata;

endmodule
`default_nettype wire
